// File: rtl/uart_line_loader_if.sv
// Line output channel of the UART line loader: a 512-bit line plus its index,
// moved with a valid/ready handshake toward the DRAM write mux.
interface uart_line_loader_if #(
  parameter int ADDR_WIDTH = 26
) ();
  logic [511:0]          line_data_o;
  logic [ADDR_WIDTH-1:0] line_addr_o;
  logic                  line_valid_o;
  logic                  line_ready_i;

  modport master (output line_data_o, line_addr_o, line_valid_o, input line_ready_i);
  modport slave  (input line_data_o, line_addr_o, line_valid_o, output line_ready_i);
endinterface

// File: rtl/uart_line_loader.sv
// 8N1 UART receiver feeding a 64-byte line assembler; completed lines are
// offered on a valid/ready port with an incrementing line index.
module uart_line_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int LINE_BYTES   = 64,
  parameter int ADDR_WIDTH   = 26,
  parameter int NUM_LINES    = 43
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx_data,
  output logic [7:0]           byte_o,
  output logic                 byte_valid_o,
  uart_line_loader_if.master   line_if,
  output logic                 done_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int TW     = $clog2(CLKS_PER_BIT);
  localparam int CW     = $clog2(LINE_BYTES);
  localparam int NW     = $clog2(NUM_LINES + 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(LINE_BYTES - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_LINES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI} rx_state_t;

  rx_state_t             state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [TW-1:0]         timer_q, timer_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            byte_q, byte_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  ferr_q, ferr_d;
  logic                  byte_good;

  logic [LINE_W-1:0]     buf_q, buf_d, line_q, line_d, merged;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ovr_q, ovr_d;
  logic                  done_q, done_d;
  logic [NW-1:0]         acc_q, acc_d;
  logic                  assemble, complete, accept;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    ferr_d    = ferr_q;
    byte_good = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          if (!sync2_q) begin
            state_d = S_DATA;
            timer_d = '0;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_STOP: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          if (sync2_q) begin
            byte_good = 1'b1;
            byte_d    = shift_q;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HI;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_HI: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    byte_valid_d = byte_good;
  end

  // The good byte is merged in the stop-sample cycle so a completed line
  // reaches the output register on the same edge that raises byte_valid_o.
  always_comb begin
    merged = buf_q;
    merged[{cnt_q, 3'b000} +: 8] = shift_q;
    assemble = byte_good && !done_q;
    complete = assemble && (cnt_q == C_LAST);
    accept   = valid_q && line_if.line_ready_i;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    ovr_d    = ovr_q;
    done_d   = done_q;
    acc_d    = acc_q;
    if (assemble) begin
      buf_d = merged;
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end
    if (accept) begin
      valid_d = 1'b0;
      addr_d  = addr_q + ADDR_WIDTH'(1);
      if (!done_q) begin
        acc_d = acc_q + NW'(1);
        if (acc_q == N_LAST) done_d = 1'b1;
      end
    end
    if (complete) begin
      if (!valid_q || accept) begin
        line_d  = merged;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    buf_q   <= buf_d;
    if (!rstn) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
      cnt_q        <= '0;
      line_q       <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      ovr_q        <= 1'b0;
      done_q       <= 1'b0;
      acc_q        <= '0;
    end else begin
      sync1_q      <= rx_data;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      ferr_q       <= ferr_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      ovr_q        <= ovr_d;
      done_q       <= done_d;
      acc_q        <= acc_d;
    end
  end

  assign byte_o               = byte_q;
  assign byte_valid_o         = byte_valid_q;
  assign frame_err_o          = ferr_q;
  assign overrun_o            = ovr_q;
  assign done_o               = done_q;
  assign line_if.line_data_o  = line_q;
  assign line_if.line_addr_o  = addr_q;
  assign line_if.line_valid_o = valid_q;
endmodule

// File: tb/tb_uart_line_loader.sv
// Bench for uart_line_loader: byte and line scoreboards fed by the stimulus,
// drained by a per-cycle monitor.
module tb_uart_line_loader;
  localparam int CPB = 16;
  localparam int LB  = 64;
  localparam int AW  = 26;
  localparam int NL  = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [511:0]  data;
    logic [AW-1:0] addr;
  } line_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx_data = 1'b1;
  logic [7:0] byte_o;
  logic byte_valid_o, done_o, frame_err_o, overrun_o;

  uart_line_loader_if #(.ADDR_WIDTH(AW)) lif ();

  uart_line_loader #(
    .CLKS_PER_BIT(CPB), .LINE_BYTES(LB), .ADDR_WIDTH(AW), .NUM_LINES(NL)
  ) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .line_if(lif),
    .done_o(done_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;
  logic [7:0] byte_sb[$];
  line_t      line_sb[$];
  int bv_n, acc_n;
  logic prev_bv, prev_valid, lv_at64, lv_before64, lv_after_done;
  logic [511:0]  prev_data;
  logic [AW-1:0] prev_addr;
  vec_t vecs[5];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    line_t l;
    if (!rstn) begin
      bv_n = 0; acc_n = 0; prev_bv = 0; prev_valid = 0;
      lv_at64 = 0; lv_before64 = 0; lv_after_done = 0;
      prev_data = '0; prev_addr = '0;
    end else begin
      if (byte_valid_o) begin
        check("byte_valid_width", prev_bv, 1'b0);
        bv_n++;
        if (byte_sb.size() == 0) begin
          chk++; err++;
          $display("FAIL unexpected_byte actual=%0h required=none", byte_o);
        end else begin
          check("byte_o", byte_o, byte_sb.pop_front());
        end
        if (bv_n == LB) begin
          lv_at64 = lif.line_valid_o;
          lv_before64 = prev_valid;
        end
      end
      prev_bv = byte_valid_o;
      // an accept happened on the edge just passed iff valid was up before it
      if (prev_valid && lif.line_ready_i) begin
        acc_n++;
        if (line_sb.size() == 0) begin
          chk++; err++;
          $display("FAIL unexpected_line actual=%0h required=none", prev_addr);
        end else begin
          l = line_sb.pop_front();
          check("line_data", prev_data, l.data);
          check("line_addr", prev_addr, l.addr);
        end
        check("done_after_accept", done_o, acc_n >= NL);
      end
      if (done_o && lif.line_valid_o) lv_after_done = 1'b1;
      prev_valid = lif.line_valid_o;
      prev_data  = lif.line_data_o;
      prev_addr  = lif.line_addr_o;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    rx_data = 1'b1;
    repeat (3) step();
    rstn = 1'b1;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_data = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rx_data = b[i];
      repeat (CPB) step();
    end
    rx_data = stop;
    repeat (CPB) step();
    rx_data = 1'b1;
    if (!stop) repeat (CPB) step();
  endtask

  task automatic send_good(input logic [7:0] b);
    byte_sb.push_back(b);
    send_byte(b, 1'b1);
  endtask

  initial begin
    line_t ln;
    logic [7:0] b;
    logic [7:0] last_good;
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h11, stop: 1'b1, exp_ferr: 1'b1};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_ferr: 1'b1};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_ferr: 1'b1};
    lif.line_ready_i = 1'b0;

    do_reset();
    check("rst_byte_o", byte_o, 8'h00);
    check("rst_byte_valid", byte_valid_o, 1'b0);
    check("rst_line_valid", lif.line_valid_o, 1'b0);
    check("rst_line_addr", lif.line_addr_o, '0);
    check("rst_line_data", lif.line_data_o, '0);
    check("rst_done", done_o, 1'b0);
    check("rst_frame_err", frame_err_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);

    last_good = 8'h00;
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].stop) begin
        byte_sb.push_back(vecs[v].data);
        last_good = vecs[v].data;
      end
      send_byte(vecs[v].data, vecs[v].stop);
      repeat (4) step();
      check("vec_byte_drained", byte_sb.size(), 0);
      check("vec_byte_hold", byte_o, last_good);
      check("vec_frame_err", frame_err_o, vecs[v].exp_ferr);
      check("vec_overrun", overrun_o, 1'b0);
    end

    // start-bit glitch shorter than half a bit
    do_reset();
    rx_data = 1'b0;
    repeat (4) step();
    rx_data = 1'b1;
    repeat (40) step();
    check("glitch_no_byte", bv_n, 0);
    check("glitch_frame_err", frame_err_o, 1'b0);
    check("glitch_overrun", overrun_o, 1'b0);
    send_good(8'h5A);
    repeat (4) step();
    check("glitch_recover", bv_n, 1);

    // one line, consumer always ready
    do_reset();
    lif.line_ready_i = 1'b1;
    ln.addr = '0;
    for (int i = 0; i < LB; i++) ln.data[8*i +: 8] = 8'(i);
    line_sb.push_back(ln);
    for (int i = 0; i < LB; i++) send_good(8'(i));
    repeat (4) step();
    check("line_valid_latency", lv_at64, 1'b1);
    check("line_valid_before", lv_before64, 1'b0);
    check("line1_accepts", acc_n, 1);
    check("line1_valid_after", lif.line_valid_o, 1'b0);
    check("line1_addr_after", lif.line_addr_o, 1);
    check("line1_overrun", overrun_o, 1'b0);

    // consumer stalled across two lines
    do_reset();
    lif.line_ready_i = 1'b0;
    ln.addr = '0;
    for (int i = 0; i < LB; i++) ln.data[8*i +: 8] = 8'(i * 7 + 3);
    line_sb.push_back(ln);
    for (int i = 0; i < 2 * LB; i++) begin
      send_good(8'(i * 7 + 3));
      if (i == LB - 1) begin
        repeat (2) step();
        check("stall_valid_first", lif.line_valid_o, 1'b1);
        check("stall_overrun_first", overrun_o, 1'b0);
      end
    end
    repeat (4) step();
    check("stall_overrun", overrun_o, 1'b1);
    check("stall_valid", lif.line_valid_o, 1'b1);
    check("stall_addr", lif.line_addr_o, 0);
    check("stall_data_kept", lif.line_data_o, ln.data);
    lif.line_ready_i = 1'b1;
    step();
    lif.line_ready_i = 1'b0;
    repeat (3) step();
    check("stall_accepts", acc_n, 1);
    check("stall_addr_after", lif.line_addr_o, 1);
    check("stall_no_pending", lif.line_valid_o, 1'b0);

    // NUM_LINES lines then one more
    do_reset();
    lif.line_ready_i = 1'b1;
    for (int k = 0; k < NL; k++) begin
      ln.addr = AW'(k);
      for (int i = 0; i < LB; i++) ln.data[8*i +: 8] = 8'((k * LB + i) ^ 8'hC3);
      line_sb.push_back(ln);
    end
    for (int i = 0; i < 3 * LB; i++) begin
      b = 8'(i ^ 8'hC3);
      send_good(b);
      if (i == LB - 1) begin
        repeat (2) step();
        check("done_after_first", done_o, 1'b0);
      end
    end
    repeat (4) step();
    check("done_set", done_o, 1'b1);
    check("done_accepts", acc_n, NL);
    check("done_no_third", lv_after_done, 1'b0);
    check("done_valid_low", lif.line_valid_o, 1'b0);
    check("done_overrun", overrun_o, 1'b0);
    check("done_bytes", bv_n, 3 * LB);
    check("sb_bytes_empty", byte_sb.size(), 0);
    check("sb_lines_empty", line_sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
